// File: rtl/m_scan7segment.sv
// m_scan7segment: N-digit time-multiplexed 7-segment driver.
// Prescaler -> scan index -> one BLANK cycle per digit change, then DRIVE
// until the next scan step. Segments and digit selects are active-low.
// Optional feature macro: SEG_BLINK_EN (adds iblink port and blink counter).
module m_scan7segment #(
  parameter int unsigned NDIG        = 4,
  parameter int unsigned CLK_DIV     = 500000,
  parameter int unsigned BLINK_TICKS = 50
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*NDIG-1:0]     idat,
  input  logic [NDIG-1:0]       ien,
  input  logic [NDIG-1:0]       idp,
`ifdef SEG_BLINK_EN
  input  logic [NDIG-1:0]       iblink,
`endif
  output logic [7:0]            odat,
  output logic [NDIG-1:0]       odig,
  output logic                  otick
);

  localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned IW = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } phase_e;

  // Segment decode, active-low a..g (bit6 = g), dp handled separately
  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h18;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h27;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  logic [CW-1:0]   cnt_q, cnt_d;
  logic [IW-1:0]   idx_q, idx_d;
  phase_e          phase_q, phase_d;
  logic [7:0]      odat_q, odat_d;
  logic [NDIG-1:0] odig_q, odig_d;
  logic            otick_q, otick_d;
  logic [3:0]      hnib_q, hnib_d;
  logic            hen_q, hen_d;
  logic            hdp_q, hdp_d;
  logic            tick;
  logic            shown;

`ifdef SEG_BLINK_EN
  localparam int unsigned BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  logic [BW-1:0]   bcnt_q, bcnt_d;
  logic            blink_off_q, blink_off_d;
  logic            hblink_q, hblink_d;
`endif

  assign tick = (cnt_q == CW'(CLK_DIV - 1));

  // Prescaler, scan index and hold registers for the digit about to be shown
  always_comb begin
    cnt_d  = tick ? '0 : cnt_q + 1'b1;
    idx_d  = idx_q;
    hnib_d = hnib_q;
    hen_d  = hen_q;
    hdp_d  = hdp_q;
`ifdef SEG_BLINK_EN
    hblink_d    = hblink_q;
    bcnt_d      = bcnt_q;
    blink_off_d = blink_off_q;
`endif
    if (tick) begin
      idx_d = (idx_q == IW'(NDIG - 1)) ? '0 : idx_q + 1'b1;
      for (int unsigned k = 0; k < NDIG; k++) begin
        if (idx_d == IW'(k)) begin
          hnib_d = idat[4*k +: 4];
          hen_d  = ien[k];
          hdp_d  = idp[k];
`ifdef SEG_BLINK_EN
          hblink_d = iblink[k];
`endif
        end
      end
`ifdef SEG_BLINK_EN
      if (bcnt_q == BW'(BLINK_TICKS - 1)) begin
        bcnt_d      = '0;
        blink_off_d = ~blink_off_q;
      end else begin
        bcnt_d = bcnt_q + 1'b1;
      end
`endif
    end
  end

  // A blinking digit in its off half-period is treated as disabled
  always_comb begin
`ifdef SEG_BLINK_EN
    shown = hen_q & ~(hblink_q & blink_off_q);
`else
    shown = hen_q;
`endif
  end

  // Phase sequencing: blank on the tick edge, drive the held digit one edge later
  always_comb begin
    phase_d = phase_q;
    odat_d  = odat_q;
    odig_d  = odig_q;
    otick_d = 1'b0;
    if (tick) begin
      phase_d = BLANK;
      odat_d  = 8'hFF;
      odig_d  = '1;
      otick_d = 1'b1;
    end else if (phase_q == BLANK && otick_q) begin
      phase_d = DRIVE;
      if (shown) begin
        for (int unsigned k = 0; k < NDIG; k++) begin
          odig_d[k] = (idx_q != IW'(k));
        end
        odat_d = {~hdp_q, seg_decode(hnib_q)};
      end else begin
        odat_d = 8'hFF;
        odig_d = '1;
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      phase_q <= BLANK;
      odat_q  <= 8'hFF;
      odig_q  <= '1;
      otick_q <= 1'b0;
      hnib_q  <= '0;
      hen_q   <= 1'b0;
      hdp_q   <= 1'b0;
`ifdef SEG_BLINK_EN
      bcnt_q      <= '0;
      blink_off_q <= 1'b0;
      hblink_q    <= 1'b0;
`endif
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      phase_q <= phase_d;
      odat_q  <= odat_d;
      odig_q  <= odig_d;
      otick_q <= otick_d;
      hnib_q  <= hnib_d;
      hen_q   <= hen_d;
      hdp_q   <= hdp_d;
`ifdef SEG_BLINK_EN
      bcnt_q      <= bcnt_d;
      blink_off_q <= blink_off_d;
      hblink_q    <= hblink_d;
`endif
    end
  end

  assign odat  = odat_q;
  assign odig  = odig_q;
  assign otick = otick_q;

endmodule
